// File: rtl/banco_registro_dual_wr.sv
// -----------------------------------------------------------------------------
// banco_registro_dual_wr
// Register bank with two combinational read ports and two write ports. It is
// the main operand store between the datapath and the control FSM.
//  - Write port 1 has priority over port 0 when both target the same address.
//  - Optional read-during-write bypass (BYPASS=1) returns same-cycle write data.
//  - Each register carries a valid bit, set by any write and cleared by reset
//    or by the clear sweep.
//  - A small sequencer clears the bank one entry per cycle on clr_req, without
//    needing a reset. While it runs, writes are dropped and flagged on wr_drop.
//
// Ports
//  clk                 rising-edge clock
//  rst                 asynchronous active-high reset
//  addrRa/addrRb       read addresses
//  datOutRa/datOutRb   read data (combinational)
//  validRa/validRb     valid bit of the addressed register
//  addrW0/datW0/we0    write port 0
//  addrW1/datW1/we1    write port 1 (priority)
//  clr_req             start a clear sweep (sampled at posedge, IDLE only)
//  busy                high while the sweep runs
//  clr_done            one-cycle pulse after the sweep
//  wr_drop             sticky flag: a write was attempted during the sweep
// -----------------------------------------------------------------------------
module banco_registro_dual_wr #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 4,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addrRa,
   input  logic [ADDR_W-1:0] addrRb,
   output logic [DATA_W-1:0] datOutRa,
   output logic [DATA_W-1:0] datOutRb,
   output logic              validRa,
   output logic              validRb,
   input  logic [ADDR_W-1:0] addrW0,
   input  logic [DATA_W-1:0] datW0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addrW1,
   input  logic [DATA_W-1:0] datW1,
   input  logic              we1,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_done,
   output logic              wr_drop
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_cnt;
   logic                r_busy;
   logic                r_done;
   logic                r_drop;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DEPTH-1:0]    r_valid;

   logic [DEPTH-1:0]    w_hit0;
   logic [DEPTH-1:0]    w_hit1;
   logic [DEPTH-1:0]    w_clr;
   logic                w_wr_en;

   // Writes (and bypass) are only honoured outside the sweep.
   assign w_wr_en = (r_state != ST_CLEAR);

   // Per-entry decode of write hits and of the sweep pointer.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
         assign w_hit0[gi] = we0 && (addrW0 == ADDR_W'(gi));
         assign w_hit1[gi] = we1 && (addrW1 == ADDR_W'(gi));
         assign w_clr[gi]  = (r_state == ST_CLEAR) && (r_cnt == ADDR_W'(gi));
      end
   endgenerate

   // Storage: the sweep clear wins, then port 1, then port 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_valid <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_clr[i]) begin
               r_mem[i]   <= '0;
               r_valid[i] <= 1'b0;
            end else if (w_wr_en && w_hit1[i]) begin
               r_mem[i]   <= datW1;
               r_valid[i] <= 1'b1;
            end else if (w_wr_en && w_hit0[i]) begin
               r_mem[i]   <= datW0;
               r_valid[i] <= 1'b1;
            end
         end
      end
   end

   // Clear sequencer. busy/clr_done are registered alongside the state so
   // they change exactly on the state transitions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (clr_req) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (we0 || we1) begin
                  r_drop <= 1'b1;
               end
               // The pointer wraps to 0 on the last entry, ending the sweep.
               r_cnt <= r_cnt + ADDR_W'(1);
               if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Read port A: stored data, overridden by a matching same-cycle write.
   always_comb begin
      datOutRa = r_mem[addrRa];
      validRa  = r_valid[addrRa];
      if (BYPASS && w_wr_en) begin
         if (we1 && (addrW1 == addrRa)) begin
            datOutRa = datW1;
            validRa  = 1'b1;
         end else if (we0 && (addrW0 == addrRa)) begin
            datOutRa = datW0;
            validRa  = 1'b1;
         end
      end
   end

   // Read port B: same rules as port A.
   always_comb begin
      datOutRb = r_mem[addrRb];
      validRb  = r_valid[addrRb];
      if (BYPASS && w_wr_en) begin
         if (we1 && (addrW1 == addrRb)) begin
            datOutRb = datW1;
            validRb  = 1'b1;
         end else if (we0 && (addrW0 == addrRb)) begin
            datOutRb = datW0;
            validRb  = 1'b1;
         end
      end
   end

   assign busy     = r_busy;
   assign clr_done = r_done;
   assign wr_drop  = r_drop;

endmodule

// File: tb/tb_banco_registro_dual_wr.sv
// -----------------------------------------------------------------------------
// tb_banco_registro_dual_wr
// Directed bench. The stimulus process drives inputs just after each rising
// edge and pushes the hand-computed expectation for that cycle into a queue;
// the monitor pops and compares at every falling edge.
// -----------------------------------------------------------------------------
module tb_banco_registro_dual_wr;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] addrRa, addrRb, addrW0, addrW1;
   logic [3:0] datOutRa, datOutRb, datW0, datW1;
   logic       validRa, validRb, we0, we1, clr_req, busy, clr_done, wr_drop;

   always #5 clk = ~clk;

   banco_registro_dual_wr #(.ADDR_W(3), .DATA_W(4), .BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst),
      .addrRa(addrRa), .addrRb(addrRb),
      .datOutRa(datOutRa), .datOutRb(datOutRb),
      .validRa(validRa), .validRb(validRb),
      .addrW0(addrW0), .datW0(datW0), .we0(we0),
      .addrW1(addrW1), .datW1(datW1), .we1(we1),
      .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop)
   );

   typedef struct {
      bit         ck_a;
      logic [3:0] da;
      logic       va;
      bit         ck_b;
      logic [3:0] db;
      logic       vb;
      bit         ck_s;
      logic       busy;
      logic       done;
      logic       drop;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_err    = 0;

   exp_t  mon_e;
   string mon_n;

   task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input string nm,
                       input bit ck_a, input logic [3:0] da, input logic va,
                       input bit ck_b, input logic [3:0] db, input logic vb,
                       input bit ck_s, input logic bz, input logic dn, input logic dr);
      exp_t e;
      e.ck_a = ck_a; e.da = da; e.va = va;
      e.ck_b = ck_b; e.db = db; e.vb = vb;
      e.ck_s = ck_s; e.busy = bz; e.done = dn; e.drop = dr;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: one line per checked transaction.
   initial begin
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            $display("[%0t] %s: Ra=%0d d=%h v=%b Rb=%0d d=%h v=%b busy=%b done=%b drop=%b",
                     $time, mon_n, addrRa, datOutRa, validRa, addrRb, datOutRb, validRb,
                     busy, clr_done, wr_drop);
            if (mon_e.ck_a) begin
               cmp({mon_n, ".datA"}, datOutRa, mon_e.da);
               cmp({mon_n, ".validA"}, {3'b0, validRa}, {3'b0, mon_e.va});
            end
            if (mon_e.ck_b) begin
               cmp({mon_n, ".datB"}, datOutRb, mon_e.db);
               cmp({mon_n, ".validB"}, {3'b0, validRb}, {3'b0, mon_e.vb});
            end
            if (mon_e.ck_s) begin
               cmp({mon_n, ".busy"}, {3'b0, busy}, {3'b0, mon_e.busy});
               cmp({mon_n, ".clr_done"}, {3'b0, clr_done}, {3'b0, mon_e.done});
               cmp({mon_n, ".wr_drop"}, {3'b0, wr_drop}, {3'b0, mon_e.drop});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, expected finish before 100000");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bank contents just before the sweep in test 5.
   logic [3:0] old_d [8];

   initial begin
      old_d[0] = 4'h0; old_d[1] = 4'h1; old_d[2] = 4'h7; old_d[3] = 4'hC;
      old_d[4] = 4'h4; old_d[5] = 4'h9; old_d[6] = 4'h6; old_d[7] = 4'h7;

      rst = 1'b1; clr_req = 1'b0;
      we0 = 1'b0; addrW0 = '0; datW0 = '0;
      we1 = 1'b0; addrW1 = '0; datW1 = '0;
      addrRa = '0; addrRb = '0;
      push("rst_hold", 1, 4'h0, 0, 1, 4'h0, 0, 1, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;

      // 1. after reset: everything zero and invalid
      for (int i = 0; i < 4; i++) begin
         addrRa = 3'(i); addrRb = 3'(i + 4);
         push("t1_reset_read", 1, 4'h0, 0, 1, 4'h0, 0, 1, 0, 0, 0);
         tick();
      end

      // 2. write j to address j via port 0
      for (int j = 0; j < 8; j++) begin
         we0 = 1'b1; addrW0 = 3'(j); datW0 = 4'(j);
         tick();
      end
      we0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         addrRa = 3'(i); addrRb = 3'(i + 4);
         push("t2_read_pair", 1, 4'(i), 1, 1, 4'(i + 4), 1, 1, 0, 0, 0);
         tick();
      end

      // 3. both ports write address 5: port 1 wins (bypass shows it too)
      we0 = 1'b1; addrW0 = 3'd5; datW0 = 4'h3;
      we1 = 1'b1; addrW1 = 3'd5; datW1 = 4'h9;
      addrRa = 3'd5; addrRb = 3'd0;
      push("t3_same_addr_bypass", 1, 4'h9, 1, 1, 4'h0, 1, 1, 0, 0, 0);
      tick();
      we0 = 1'b0; we1 = 1'b0;
      addrRa = 3'd5; addrRb = 3'd4;
      push("t3_same_addr_stored", 1, 4'h9, 1, 1, 4'h4, 1, 1, 0, 0, 0);
      tick();

      // 4. bypass on both read ports from different write ports
      we1 = 1'b1; addrW1 = 3'd2; datW1 = 4'h7;
      we0 = 1'b1; addrW0 = 3'd3; datW0 = 4'hC;
      addrRa = 3'd2; addrRb = 3'd3;
      push("t4_bypass", 1, 4'h7, 1, 1, 4'hC, 1, 1, 0, 0, 0);
      tick();
      we0 = 1'b0; we1 = 1'b0;
      push("t4_stored", 1, 4'h7, 1, 1, 4'hC, 1, 1, 0, 0, 0);
      tick();

      // 5. clear sweep: cycle k has pointer k-1; entries below it are cleared
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         addrRa = 3'(k - 1);
         if (k == 1) begin
            addrRb = 3'd7;
            push("t5_sweep", 1, old_d[k - 1], 1, 1, old_d[7], 1, 1, 1, 0, 0);
         end else begin
            addrRb = 3'(k - 2);
            if (k == 3) begin
               // write during the sweep: dropped, and no bypass onto port B
               we0 = 1'b1; addrW0 = 3'd1; datW0 = 4'hF;
            end
            push("t5_sweep", 1, old_d[k - 1], 1, 1, 4'h0, 0, 1, 1, 0, (k >= 4));
         end
         tick();
         we0 = 1'b0;
      end
      addrRa = 3'd1; addrRb = 3'd7;
      push("t5_done_pulse", 1, 4'h0, 0, 1, 4'h0, 0, 1, 0, 1, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         addrRa = 3'(i); addrRb = 3'(i + 4);
         push("t5_after_clear", 1, 4'h0, 0, 1, 4'h0, 0, 1, 0, 0, 1);
         tick();
      end

      // 6. reset in the middle of a sweep
      we0 = 1'b1; addrW0 = 3'd0; datW0 = 4'hA;
      we1 = 1'b1; addrW1 = 3'd6; datW1 = 4'h5;
      tick();
      we0 = 1'b0; we1 = 1'b0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick();
      tick();
      addrRa = 3'd6; addrRb = 3'd0;
      push("t6_sweep_cycle3", 1, 4'h5, 1, 1, 4'h0, 0, 1, 1, 0, 1);
      tick();
      rst = 1'b1;
      push("t6_rst_asserted", 1, 4'h0, 0, 1, 4'h0, 0, 1, 0, 0, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         addrRa = 3'(i); addrRb = 3'(i + 4);
         push("t6_after_rst", 1, 4'h0, 0, 1, 4'h0, 0, 1, 0, 0, 0);
         tick();
      end
      // the sequencer is back in IDLE: writes are accepted again
      we1 = 1'b1; addrW1 = 3'd4; datW1 = 4'h3;
      tick();
      we1 = 1'b0;
      addrRa = 3'd4; addrRb = 3'd6;
      push("t6_write_after_rst", 1, 4'h3, 1, 1, 4'h0, 0, 1, 0, 0, 0);
      tick();
      tick();

      n_checks++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain: %0d pending, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
